// File: rtl/spectrogram_frame_receiver.sv
// spectrogram_frame_receiver: serial-to-parallel receiver for the spectrogram
// extractor's output link. A frame_start strobe marks the MSB of word 0 (RTC).
// The frame carries NUM_WORDS words of WORD_W bits each, MSB first, with no gaps
// between words. After the last word there is one GAP cycle.
// Optional feature: define RX_RESYNC_EN so that a frame_start seen during RX
// restarts reception and pulses frame_err.
module spectrogram_frame_receiver #(
    parameter int WORD_W    = 12,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              sdata,
    output logic [WORD_W-1:0] word,
    output logic [3:0]        chan,
    output logic              word_valid,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [3:0] LAST_BIT  = 4'(WORD_W - 1);
    localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RX, GAP} state_t;

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [3:0]        word_cnt, word_cnt_n;
    logic [WORD_W-1:0] sr, sr_n, shifted;
    logic [WORD_W-1:0] word_n;
    logic [3:0]        chan_n;
    logic              word_valid_n, frame_done_n, frame_err_n, busy_n;
    logic              resync;

    assign shifted = {sr[WORD_W-2:0], sdata};

`ifdef RX_RESYNC_EN
    assign resync = (state == RX) && frame_start;
`else
    assign resync = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        word_cnt_n   = word_cnt;
        sr_n         = sr;
        word_n       = word;
        chan_n       = chan;
        word_valid_n = 1'b0;
        frame_done_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    sr_n       = shifted;
                    bit_cnt_n  = 4'd1;
                    word_cnt_n = 4'd0;
                    state_n    = RX;
                end
            end
            RX: begin
                sr_n = shifted;
                if (resync) begin
                    // Treat this edge as word 0 MSB. Any word completing on this edge is dropped.
                    bit_cnt_n   = 4'd1;
                    word_cnt_n  = 4'd0;
                    frame_err_n = 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    word_n       = shifted;
                    chan_n       = word_cnt;
                    word_valid_n = 1'b1;
                    bit_cnt_n    = 4'd0;
                    word_cnt_n   = word_cnt + 4'd1;
                    if (word_cnt == LAST_WORD) begin
                        frame_done_n = 1'b1;
                        word_cnt_n   = 4'd0;
                        state_n      = GAP;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, counters and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            sr         <= '0;
            word       <= '0;
            chan       <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            word_cnt   <= word_cnt_n;
            sr         <= sr_n;
            word       <= word_n;
            chan       <= chan_n;
            word_valid <= word_valid_n;
            frame_done <= frame_done_n;
            frame_err  <= frame_err_n;
            busy       <= busy_n;
        end
    end

endmodule
